// File: rtl/rvfi_trace_buffer_if.sv
// rtl/rvfi_trace_buffer_if.sv - RVFI retirement input and trace output bundle
interface rvfi_trace_buffer_if;
  logic        rvfi_valid;
  logic        rvfi_trap;
  logic        rvfi_intr;
  logic [1:0]  rvfi_mode;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_insn;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;

  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [31:0] trace_pc_o;
  logic [31:0] trace_insn_o;
  logic [31:0] trace_rd_wdata_o;
  logic [4:0]  trace_rd_addr_o;
  logic [1:0]  trace_mode_o;
  logic        trace_trap_o;
  logic        trace_intr_o;
  logic        trace_gap_o;

  // Core plus trace consumer side.
  modport master (
    output rvfi_valid, rvfi_trap, rvfi_intr, rvfi_mode, rvfi_pc_rdata,
           rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata, trace_ready_i,
    input  trace_valid_o, trace_pc_o, trace_insn_o, trace_rd_wdata_o,
           trace_rd_addr_o, trace_mode_o, trace_trap_o, trace_intr_o, trace_gap_o
  );

  // Trace buffer side.
  modport slave (
    input  rvfi_valid, rvfi_trap, rvfi_intr, rvfi_mode, rvfi_pc_rdata,
           rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata, trace_ready_i,
    output trace_valid_o, trace_pc_o, trace_insn_o, trace_rd_wdata_o,
           trace_rd_addr_o, trace_mode_o, trace_trap_o, trace_intr_o, trace_gap_o
  );
endinterface

// File: rtl/rvfi_trace_buffer.sv
// rtl/rvfi_trace_buffer.sv - RVFI retirement trace FIFO with drop accounting and freeze-on-trap
module rvfi_trace_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     enable_i,
  input  logic                     freeze_on_trap_i,
  input  logic                     flush_i,
  input  logic                     clear_cnt_i,
  rvfi_trace_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [15:0]              drop_cnt_o,
  output logic                     frozen_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_FROZEN} state_t;

  typedef struct packed {
    logic        trap;
    logic        intr;
    logic [1:0]  mode;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        gap;
  } rec_t;

  state_t        state_q, state_d;
  rec_t          mem_q [DEPTH];
  rec_t          head_q, head_d, in_rec;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d, level_after_pop;
  logic [15:0]   drop_q, drop_d;
  logic          gap_q, gap_d;
  logic          capture, pop, full, write, drop;

  // Qualify the retirement and decide whether it is stored, dropped or flushed away.
  always_comb begin
    in_rec   = '{trap:     bus.rvfi_trap,
                 intr:     bus.rvfi_intr,
                 mode:     bus.rvfi_mode,
                 pc:       bus.rvfi_pc_rdata,
                 insn:     bus.rvfi_insn,
                 rd_addr:  bus.rvfi_rd_addr,
                 rd_wdata: bus.rvfi_rd_wdata,
                 gap:      gap_q};
    capture  = bus.rvfi_valid && (state_q == ST_RUN);
    pop      = (level_q != '0) && bus.trace_ready_i && !flush_i;
    full     = (level_q == LW'(DEPTH));
    write    = capture && (!full || pop) && !flush_i;
    drop     = capture && full && !pop && !flush_i;
  end

  // FIFO pointers, occupancy, gap marker and the registered head record.
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    level_d         = level_q;
    gap_d           = gap_q;
    head_d          = head_q;
    level_after_pop = level_q - LW'(pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      gap_d    = 1'b0;
    end else begin
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      if (write) wr_ptr_d = wr_ptr_q + PW'(1);
      level_d = level_after_pop + LW'(write);
      if (write)     gap_d = 1'b0;
      else if (drop) gap_d = 1'b1;
      // The head either already sits in memory or is the record arriving now.
      if (level_d != '0) begin
        if (level_after_pop == '0) head_d = in_rec;
        else                       head_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Saturating drop counter; a clear still counts a drop in the same cycle.
  always_comb begin
    drop_d = drop_q;
    if (clear_cnt_i)                  drop_d = {15'b0, drop};
    else if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  // Capture FSM next state; disabling wins over every other transition.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:    state_d = ST_RUN;
        ST_RUN:    if (capture && bus.rvfi_trap && freeze_on_trap_i) state_d = ST_FROZEN;
        ST_FROZEN: if (flush_i) state_d = ST_RUN;
        default:   state_d = ST_OFF;
      endcase
    end
  end

  // Control and head registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_OFF;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      gap_q    <= 1'b0;
      drop_q   <= '0;
      head_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      gap_q    <= gap_d;
      drop_q   <= drop_d;
      head_q   <= head_d;
    end
  end

  // Record storage; contents need no reset because level gates visibility.
  always_ff @(posedge CLK) begin
    if (!RST && write) mem_q[wr_ptr_q] <= in_rec;
  end

  assign bus.trace_valid_o    = (level_q != '0);
  assign bus.trace_pc_o       = head_q.pc;
  assign bus.trace_insn_o     = head_q.insn;
  assign bus.trace_rd_wdata_o = head_q.rd_wdata;
  assign bus.trace_rd_addr_o  = head_q.rd_addr;
  assign bus.trace_mode_o     = head_q.mode;
  assign bus.trace_trap_o     = head_q.trap;
  assign bus.trace_intr_o     = head_q.intr;
  assign bus.trace_gap_o      = head_q.gap;
  assign level_o              = level_q;
  assign drop_cnt_o           = drop_q;
  assign frozen_o             = (state_q == ST_FROZEN);
endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// tb/tb_rvfi_trace_buffer.sv - self-checking bench for rvfi_trace_buffer
module tb_rvfi_trace_buffer;
  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RST, en, frz, flush, clr;
  logic [4:0]  level;
  logic [15:0] dcnt;
  logic        frozen;

  always #5 CLK = ~CLK;

  rvfi_trace_buffer_if ifc ();

  rvfi_trace_buffer #(.DEPTH(DEPTH)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .enable_i         (en),
    .freeze_on_trap_i (frz),
    .flush_i          (flush),
    .clear_cnt_i      (clr),
    .bus              (ifc.slave),
    .level_o          (level),
    .drop_cnt_o       (dcnt),
    .frozen_o         (frozen)
  );

  typedef struct packed {
    bit        trap;
    bit        intr;
    bit [1:0]  mode;
    bit [31:0] pc;
    bit [31:0] insn;
    bit [4:0]  rd;
    bit [31:0] wd;
    bit        gap;
  } mrec_t;

  // Reference model: queue of records, plain-int state and counters.
  mrec_t mq[$];
  mrec_t mlast;
  int    mstate;   // 0 off, 1 run, 2 frozen
  int    mdrop;
  bit    mgap;
  bit    quiet;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit        en, valid, trap, ready;
    bit [31:0] pc;
    bit        exp_valid;
    int        exp_level;
    bit [31:0] exp_pc;
    bit        exp_gap;
    int        exp_drop;
    bit        exp_frozen;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_step();
    bit    capture, do_drop;
    mrec_t r;
    if (RST) begin
      mq.delete();
      mstate = 0;
      mdrop  = 0;
      mgap   = 0;
      mlast  = '0;
      return;
    end
    capture = ifc.rvfi_valid && (mstate == 1);
    do_drop = 0;
    if (flush) begin
      mq.delete();
      mgap = 0;
    end else begin
      if (mq.size() > 0 && ifc.trace_ready_i) void'(mq.pop_front());
      if (capture) begin
        if (mq.size() < DEPTH) begin
          r = '{trap: ifc.rvfi_trap, intr: ifc.rvfi_intr, mode: ifc.rvfi_mode,
                pc: ifc.rvfi_pc_rdata, insn: ifc.rvfi_insn, rd: ifc.rvfi_rd_addr,
                wd: ifc.rvfi_rd_wdata, gap: mgap};
          mq.push_back(r);
          mgap = 0;
        end else begin
          do_drop = 1;
          mgap    = 1;
        end
      end
    end
    if (clr)          mdrop = do_drop ? 1 : 0;
    else if (do_drop) mdrop = (mdrop >= 65535) ? 65535 : mdrop + 1;
    if (!en)                                          mstate = 0;
    else if (mstate == 0)                             mstate = 1;
    else if (mstate == 1 && capture && ifc.rvfi_trap && frz) mstate = 2;
    else if (mstate == 2 && flush)                    mstate = 1;
    if (mq.size() > 0) mlast = mq[0];
  endtask

  task automatic check_model();
    check("valid",  ifc.trace_valid_o,    mq.size() != 0);
    check("level",  level,                mq.size());
    check("drop",   dcnt,                 mdrop);
    check("frozen", frozen,               mstate == 2);
    check("pc",     ifc.trace_pc_o,       mlast.pc);
    check("insn",   ifc.trace_insn_o,     mlast.insn);
    check("rd",     ifc.trace_rd_addr_o,  mlast.rd);
    check("wdata",  ifc.trace_rd_wdata_o, mlast.wd);
    check("mode",   ifc.trace_mode_o,     mlast.mode);
    check("trap",   ifc.trace_trap_o,     mlast.trap);
    check("intr",   ifc.trace_intr_o,     mlast.intr);
    check("gap",    ifc.trace_gap_o,      mlast.gap);
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
    if (!quiet) check_model();
  endtask

  task automatic idle();
    RST = 0; flush = 0; clr = 0;
    ifc.rvfi_valid = 0; ifc.rvfi_trap = 0; ifc.rvfi_intr = 0; ifc.rvfi_mode = 2'd3;
    ifc.rvfi_pc_rdata = '0; ifc.rvfi_insn = '0; ifc.rvfi_rd_addr = '0; ifc.rvfi_rd_wdata = '0;
    ifc.trace_ready_i = 0;
  endtask

  task automatic retire(input bit [31:0] pc, input bit trap);
    ifc.rvfi_valid = 1; ifc.rvfi_trap = trap; ifc.rvfi_pc_rdata = pc;
    ifc.rvfi_insn = pc ^ 32'h0000_0013; ifc.rvfi_rd_addr = pc[6:2]; ifc.rvfi_rd_wdata = ~pc;
  endtask

  task automatic do_reset();
    idle(); en = 0; frz = 0; RST = 1;
    step();
    RST = 0;
  endtask

  initial begin
    idle(); en = 0; frz = 0; quiet = 0;

    // Table: single retirement, pop, then OFF ignoring retirements.
    tbl[0] = '{1,0,0,0,32'h000, 0,0,32'h000,0,0,0};
    tbl[1] = '{1,1,0,1,32'h100, 1,1,32'h100,0,0,0};
    tbl[2] = '{1,0,0,1,32'h000, 0,0,32'h100,0,0,0};
    tbl[3] = '{1,1,1,0,32'h200, 1,1,32'h200,0,0,0};
    tbl[4] = '{0,0,0,0,32'h000, 1,1,32'h200,0,0,0};
    tbl[5] = '{0,1,0,0,32'h300, 1,1,32'h200,0,0,0};
    tbl[6] = '{0,0,0,1,32'h000, 0,0,32'h200,0,0,0};
    do_reset();
    check("rst_valid", ifc.trace_valid_o, 0);
    check("rst_level", level, 0);
    check("rst_pc", ifc.trace_pc_o, 0);
    for (int i = 0; i < 7; i++) begin
      idle();
      en = tbl[i].en;
      ifc.rvfi_valid = tbl[i].valid; ifc.rvfi_trap = tbl[i].trap;
      ifc.rvfi_pc_rdata = tbl[i].pc; ifc.rvfi_insn = 32'h0050_0093;
      ifc.rvfi_rd_addr = 5'd1; ifc.rvfi_rd_wdata = 32'd5;
      ifc.trace_ready_i = tbl[i].ready;
      step();
      check($sformatf("tbl%0d_valid", i), ifc.trace_valid_o, tbl[i].exp_valid);
      check($sformatf("tbl%0d_level", i), level, tbl[i].exp_level);
      check($sformatf("tbl%0d_pc", i), ifc.trace_pc_o, tbl[i].exp_pc);
      check($sformatf("tbl%0d_gap", i), ifc.trace_gap_o, tbl[i].exp_gap);
      check($sformatf("tbl%0d_drop", i), dcnt, tbl[i].exp_drop);
      check($sformatf("tbl%0d_frozen", i), frozen, tbl[i].exp_frozen);
      if (i == 1) begin
        check("tbl1_insn", ifc.trace_insn_o, 32'h0050_0093);
        check("tbl1_rd", ifc.trace_rd_addr_o, 1);
        check("tbl1_wdata", ifc.trace_rd_wdata_o, 5);
      end
    end

    // Overflow: 20 retirements into 16 entries, drain, then gap marker.
    do_reset(); en = 1; step();
    for (int i = 0; i < 20; i++) begin retire(32'h1000 + 4*i, 0); step(); end
    idle();
    check("ovf_level", level, 16);
    check("ovf_drop", dcnt, 4);
    ifc.trace_ready_i = 1;
    for (int i = 0; i < 16; i++) begin
      check("drain_pc", ifc.trace_pc_o, 32'h1000 + 4*i);
      step();
    end
    check("drain_level", level, 0);
    idle(); retire(32'h2000, 0); step();
    idle();
    check("gap_valid", ifc.trace_valid_o, 1);
    check("gap_pc", ifc.trace_pc_o, 32'h2000);
    check("gap_flag", ifc.trace_gap_o, 1);
    ifc.trace_ready_i = 1; step(); idle();

    // Full FIFO with simultaneous retirement and pop.
    do_reset(); en = 1; step();
    for (int i = 0; i < 16; i++) begin retire(32'h3000 + 4*i, 0); step(); end
    retire(32'h4000, 0); ifc.trace_ready_i = 1; step(); idle();
    check("fullpop_level", level, 16);
    check("fullpop_drop", dcnt, 0);
    check("fullpop_head", ifc.trace_pc_o, 32'h3004);
    ifc.trace_ready_i = 1;
    for (int i = 0; i < 16; i++) step();
    check("fullpop_last", ifc.trace_pc_o, 32'h4000);
    check("fullpop_lastgap", ifc.trace_gap_o, 0);

    // Freeze on trap, then flush back to RUN.
    do_reset(); en = 1; frz = 1; step();
    retire(32'h500, 0); step();
    retire(32'h504, 1); step();
    retire(32'h508, 0); step();
    idle();
    check("frz_level", level, 2);
    check("frz_frozen", frozen, 1);
    check("frz_drop", dcnt, 0);
    check("frz_head", ifc.trace_pc_o, 32'h500);
    flush = 1; retire(32'h50c, 0); step(); idle();
    check("flush_level", level, 0);
    check("flush_frozen", frozen, 0);
    retire(32'h510, 0); step(); idle();
    check("run_after_flush", level, 1);
    frz = 0;

    // Drop counter saturation and clear-with-drop.
    do_reset(); en = 1; step();
    quiet = 1;
    for (int i = 0; i < 16 + 65535; i++) begin retire(32'h6000 + 4*(i % 64), 0); step(); end
    quiet = 0;
    check_model();
    check("sat_preload", dcnt, 16'hFFFF);
    step();
    check("sat_hold", dcnt, 16'hFFFF);
    clr = 1; step();
    check("clr_with_drop", dcnt, 1);
    idle(); clr = 1; step(); idle();
    check("clr_alone", dcnt, 0);

    // Reset while frozen with five records buffered.
    do_reset(); en = 1; frz = 1; step();
    for (int i = 0; i < 5; i++) begin retire(32'h700 + 4*i, i == 4); step(); end
    idle();
    check("pre_rst_level", level, 5);
    check("pre_rst_frozen", frozen, 1);
    RST = 1; step(); RST = 0;
    check("rst_frz_level", level, 0);
    check("rst_frz_valid", ifc.trace_valid_o, 0);
    check("rst_frz_frozen", frozen, 0);
    check("rst_frz_drop", dcnt, 0);
    check("rst_frz_pc", ifc.trace_pc_o, 0);
    frz = 0;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      rdy_pct = (i / 500) % 2 ? 25 : 70;
      RST   = ($urandom_range(0, 299) == 0);
      en    = ($urandom_range(0, 99) < 92);
      frz   = ($urandom_range(0, 99) < 30);
      flush = ($urandom_range(0, 29) == 0);
      clr   = ($urandom_range(0, 39) == 0);
      ifc.rvfi_valid    = ($urandom_range(0, 99) < 60);
      ifc.rvfi_trap     = ($urandom_range(0, 7) == 0);
      ifc.rvfi_intr     = ($urandom_range(0, 7) == 0);
      ifc.rvfi_mode     = 2'($urandom_range(0, 3));
      ifc.rvfi_pc_rdata = $urandom;
      ifc.rvfi_insn     = $urandom;
      ifc.rvfi_rd_addr  = 5'($urandom_range(0, 31));
      ifc.rvfi_rd_wdata = $urandom;
      ifc.trace_ready_i = ($urandom_range(0, 99) < rdy_pct);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rvfi_trace_buffer.md
RVFI_TRACE_BUFFER -- requirements
Module: rvfi_trace_buffer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving FIFO entries; it is a power of two and at least 2.
REQ-003 The block SHALL have these ports:
- CLK  in  1  clock
- RST  in  1  sync active-high reset
- enable_i  in  1  capture enable
- freeze_on_trap_i  in  1  stop capture after a trapped retirement
- flush_i  in  1  discard all buffered records
- clear_cnt_i  in  1  clear drop counter
- rvfi_valid  in  1  retirement strobe
- rvfi_trap  in  1  retired instruction trapped
- rvfi_intr  in  1  first instruction of a trap handler
- rvfi_mode  in  2  privilege mode
- rvfi_pc_rdata  in  32  retired PC
- rvfi_insn  in  32  instruction word
- rvfi_rd_addr  in  5  destination register
- rvfi_rd_wdata  in  32  destination write data
- trace_valid_o  out  1  head record valid
- trace_ready_i  in  1  consumer accepts head record
- trace_pc_o / trace_insn_o / trace_rd_wdata_o  out  32 each  head fields
- trace_rd_addr_o  out  5; trace_mode_o  out  2; trace_trap_o, trace_intr_o  out  1 each
- trace_gap_o  out  1  records were lost immediately before this one
- level_o  out  $clog2(DEPTH)+1  occupied entries
- drop_cnt_o  out  16  saturating count of lost records
- frozen_o  out  1  FSM in FROZEN

Function
REQ-004 The FSM SHALL have three states, OFF, RUN and FROZEN.
- OFF->RUN when enable_i=1.
- RUN->OFF and FROZEN->OFF when enable_i=0; this transition takes priority.
- RUN->FROZEN when a record with rvfi_trap=1 is captured while freeze_on_trap_i=1.
- FROZEN->RUN on flush_i=1 while enable_i=1.
REQ-005 A capture SHALL occur when rvfi_valid=1 and the state is RUN.
- rvfi_valid in OFF or FROZEN is ignored and is not counted as a drop.
- The trap record that causes the freeze is stored.
REQ-006 A captured record SHALL be written to the FIFO if the FIFO is not full, or if it is full and a pop occurs in the same cycle; otherwise it is dropped.
REQ-007 A pop SHALL occur when trace_valid_o=1 and trace_ready_i=1.
REQ-008 The FIFO SHALL present its head record on the trace_* outputs, with trace_valid_o = (level_o != 0).
- The fields are stable while trace_valid_o=1 and trace_ready_i=0.
REQ-009 Latency SHALL be one cycle: a record captured in cycle N into an empty FIFO appears with trace_valid_o=1 in cycle N+1.
REQ-010 level_o SHALL increment on a write without a pop, decrement on a pop without a write, and stay unchanged when both occur.
- level_o never exceeds DEPTH.
- Read and write pointers wrap modulo DEPTH.
REQ-011 On a drop, drop_cnt_o SHALL increment and saturate at 16'hFFFF, and an internal gap_pending flag SHALL set.
REQ-012 The next written record SHALL carry gap=1 when gap_pending=1, and gap_pending SHALL clear on that write.
REQ-013 clear_cnt_i SHALL zero drop_cnt_o; if a drop occurs in the same cycle, drop_cnt_o becomes 1.
REQ-014 flush_i SHALL override push and pop in that cycle.
- level_o becomes 0 and gap_pending clears.
- A same-cycle capture is discarded and not counted as a drop.
- drop_cnt_o is not affected.
REQ-015 While trace_valid_o=0, trace_* data outputs SHALL hold their last value; consumers ignore them.

Reset
REQ-016 With RST=1 at a rising CLK edge, the block SHALL, in the following cycle:
- be in state OFF;
- have an empty FIFO and level_o=0;
- drive trace_valid_o=0, drop_cnt_o=0, frozen_o=0;
- have gap_pending=0 and all trace_* outputs 0.
REQ-017 Reset SHALL override every other input, including mid-stream and while FROZEN.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- enable_i=1, trace_ready_i=1, single retirement pc=0x100, insn=0x00500093, rd=1, wdata=5 -> next cycle trace_valid_o=1 with those fields; level_o=1; gap=0.
- DEPTH=16, trace_ready_i=0, 20 retirements -> level_o=16; drop_cnt_o=4; after draining 16 records, the 21st retirement's record has trace_gap_o=1.
- FIFO full and, in one cycle, a retirement plus trace_ready_i=1 -> no drop; level_o stays 16; head advances.
- freeze_on_trap_i=1; retirements with trap=0, trap=1, trap=0 -> first two buffered, third ignored; frozen_o=1; drop_cnt_o unchanged; then flush_i=1 -> level_o=0, state RUN.
- drop_cnt_o preloaded to 0xFFFF by sustained overflow, one more drop -> stays 0xFFFF; then clear_cnt_i together with a drop -> 1.
- RST=1 asserted with level_o=5 and FROZEN -> next cycle level_o=0, trace_valid_o=0, frozen_o=0, drop_cnt_o=0.
